// File: rtl/control_unit_types_pkg.sv
// Control-path types: hazard-unit FSM encoding.
package control_unit_types_pkg;
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        DWAIT   = 2'd2,
        HALTED  = 2'd3
    } hzstate_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined CPU.
package cpu_types_pkg;
    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam word_t WORD_MAX = '1;
endpackage

// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline control and the hazard unit.
interface hazard_unit_if
    import cpu_types_pkg::*;
(
    input logic CLK,
    input logic nRST
);
    logic     ihit, dhit;
    logic     mem_dREN, mem_dWEN;
    logic     ex_dREN;
    regbits_t ex_rt, id_rs, id_rt;
    logic     id_usesrt, id_jump, mem_brtaken, wb_halt;
    logic     pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic     ifid_flush, idex_flush, exmem_flush;
    logic     halt;
    word_t    stall_cnt;

    modport hu (
        input  CLK, nRST, ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_rt, id_rs, id_rt,
               id_usesrt, id_jump, mem_brtaken, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
    );

    modport tb (
        input  CLK, nRST, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt, stall_cnt,
        output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_rt, id_rs, id_rt,
               id_usesrt, id_jump, mem_brtaken, wb_halt
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard control: memory-wait freeze, load-use stall, branch/jump flush, halt.
//   state   | meaning
//   RUN     | normal issue, all hazards checked
//   LDSTALL | one bubble cycle after a load-use stall
//   DWAIT   | frozen waiting for data memory
//   HALTED  | halt reached WB, everything off until reset
module hazard_unit
    import cpu_types_pkg::*;
    import control_unit_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     mem_dREN,
    input  logic     mem_dWEN,
    input  logic     ex_dREN,
    input  regbits_t ex_rt,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_usesrt,
    input  logic     id_jump,
    input  logic     mem_brtaken,
    input  logic     wb_halt,
    output logic     pc_en,
    output logic     ifid_en,
    output logic     idex_en,
    output logic     exmem_en,
    output logic     memwb_en,
    output logic     ifid_flush,
    output logic     idex_flush,
    output logic     exmem_flush,
    output logic     halt,
    output word_t    stall_cnt
);
    hzstate_t state, next_state;
    word_t    cnt_q;
    logic     dwait, loaduse;

    assign dwait   = (mem_dREN | mem_dWEN) & ~dhit;
    assign loaduse = ex_dREN & (ex_rt != '0) &
                     ((ex_rt == id_rs) | (id_usesrt & (ex_rt == id_rt)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halt        = 1'b0;
        next_state  = state;

        case (state)
            HALTED: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                halt     = 1'b1;
            end
            DWAIT: begin
                if (dwait) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end else begin
                    next_state = RUN;
                end
            end
            default: begin
                // LDSTALL falls through the same decode but never re-triggers the stall
                next_state = RUN;
                if (dwait) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_en    = 1'b0;
                    exmem_en   = 1'b0;
                    memwb_en   = 1'b0;
                    next_state = DWAIT;
                end else if (mem_brtaken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if ((state == RUN) && loaduse) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    next_state = LDSTALL;
                end else if (id_jump) begin
                    ifid_flush = 1'b1;
                end else if (!ihit) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
        endcase

        if (wb_halt) begin
            next_state = HALTED;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if ((state != HALTED) && !pc_en && (cnt_q != WORD_MAX)) begin
            cnt_q <= cnt_q + word_t'(1);
        end
    end

    assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed scenarios plus random traffic against a flag-based reference model.
module tb_hazard_unit;
    logic CLK;
    logic nRST;
    int   errors = 0;
    int   checks = 0;

    logic        m_halted, m_wait, m_ld;
    logic [31:0] m_cnt;

    hazard_unit_if hif (.CLK(CLK), .nRST(nRST));

    hazard_unit dut (
        .CLK(CLK), .nRST(nRST),
        .ihit(hif.ihit), .dhit(hif.dhit),
        .mem_dREN(hif.mem_dREN), .mem_dWEN(hif.mem_dWEN),
        .ex_dREN(hif.ex_dREN), .ex_rt(hif.ex_rt),
        .id_rs(hif.id_rs), .id_rt(hif.id_rt), .id_usesrt(hif.id_usesrt),
        .id_jump(hif.id_jump), .mem_brtaken(hif.mem_brtaken), .wb_halt(hif.wb_halt),
        .pc_en(hif.pc_en), .ifid_en(hif.ifid_en), .idex_en(hif.idex_en),
        .exmem_en(hif.exmem_en), .memwb_en(hif.memwb_en),
        .ifid_flush(hif.ifid_flush), .idex_flush(hif.idex_flush),
        .exmem_flush(hif.exmem_flush), .halt(hif.halt), .stall_cnt(hif.stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle();
        hif.ihit = 1'b1; hif.dhit = 1'b0; hif.mem_dREN = 1'b0; hif.mem_dWEN = 1'b0;
        hif.ex_dREN = 1'b0; hif.ex_rt = '0; hif.id_rs = '0; hif.id_rt = '0;
        hif.id_usesrt = 1'b0; hif.id_jump = 1'b0; hif.mem_brtaken = 1'b0; hif.wb_halt = 1'b0;
    endtask

    task automatic model_clear();
        m_halted = 1'b0; m_wait = 1'b0; m_ld = 1'b0; m_cnt = 32'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected vector {pc,ifid,idex,exmem,memwb,ifid_fl,idex_fl,exmem_fl,halt}
    task automatic cycle(input string tag);
        logic       dw, lu, n_halted, n_wait, n_ld;
        logic [8:0] e, o;
        #1;
        dw = (hif.mem_dREN | hif.mem_dWEN) & ~hif.dhit;
        lu = hif.ex_dREN && (hif.ex_rt != 0) &&
             ((hif.ex_rt == hif.id_rs) || (hif.id_usesrt && (hif.ex_rt == hif.id_rt)));
        n_halted = m_halted; n_wait = 1'b0; n_ld = 1'b0;
        if (m_halted)                  e = 9'b00000_000_1;
        else if (m_wait) begin
            if (dw) begin e = 9'b00000_000_0; n_wait = 1'b1; end
            else          e = 9'b11111_000_0;
        end
        else if (dw) begin             e = 9'b00000_000_0; n_wait = 1'b1; end
        else if (hif.mem_brtaken)      e = 9'b11111_111_0;
        else if (!m_ld && lu) begin    e = 9'b00111_010_0; n_ld = 1'b1; end
        else if (hif.id_jump)          e = 9'b11111_100_0;
        else if (!hif.ihit)            e = 9'b01111_100_0;
        else                           e = 9'b11111_000_0;
        if (hif.wb_halt) n_halted = 1'b1;

        o = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
             hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.halt};
        chk({tag, ".ctl"}, 32'(o), 32'(e));
        chk({tag, ".cnt"}, hif.stall_cnt, m_cnt);

        @(posedge CLK);
        if (!nRST) model_clear();
        else begin
            if (!m_halted && !e[8] && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 1;
            m_halted = n_halted; m_wait = n_wait; m_ld = n_ld;
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        model_clear();
    endtask

    initial begin
        idle();
        model_clear();
        nRST = 1'b0;
        @(negedge CLK);
        cycle("reset");
        cycle("reset2");
        nRST = 1'b1;
        cycle("idle");

        // Load-use on rs: one bubble, then a free cycle
        hif.ex_dREN = 1'b1; hif.ex_rt = 5'd5; hif.id_rs = 5'd5;
        cycle("s1.stall");
        cycle("s1.ldstall");
        idle();
        cycle("s1.after");
        chk("s1.cnt", hif.stall_cnt, 32'd1);

        // Load into r0 is never a hazard
        hif.ex_dREN = 1'b1; hif.ex_rt = 5'd0; hif.id_rs = 5'd0;
        cycle("s2.r0");
        idle();

        // Memory wait three cycles then dhit
        do_reset(); @(negedge CLK); nRST = 1'b1;
        hif.mem_dREN = 1'b1; hif.dhit = 1'b0;
        cycle("s3.w1"); cycle("s3.w2"); cycle("s3.w3");
        hif.dhit = 1'b1;
        cycle("s3.hit");
        idle();
        cycle("s3.run");
        chk("s3.cnt", hif.stall_cnt, 32'd3);

        // Branch beats load-use, stays in RUN
        hif.mem_brtaken = 1'b1; hif.ex_dREN = 1'b1; hif.ex_rt = 5'd7;
        hif.id_rt = 5'd7; hif.id_usesrt = 1'b1;
        cycle("s4.br");
        hif.mem_brtaken = 1'b0; hif.id_jump = 1'b1;
        cycle("s4.lu_over_jump");
        idle(); hif.id_jump = 1'b1;
        cycle("s4.jump");
        idle(); hif.ihit = 1'b0;
        cycle("s4.imiss");
        idle();

        // Reset in the middle of DWAIT and LDSTALL
        hif.mem_dWEN = 1'b1;
        cycle("r.dw1");
        idle(); hif.ex_dREN = 1'b1; hif.ex_rt = 5'd3; hif.id_rs = 5'd3;
        do_reset();
        cycle("r.dw_rst");
        nRST = 1'b1;
        cycle("r.lu");
        do_reset();
        cycle("r.ld_rst");
        nRST = 1'b1;
        idle();

        // Halt is sticky regardless of inputs
        hif.wb_halt = 1'b1;
        cycle("s5.pulse");
        hif.wb_halt = 1'b0; hif.ihit = 1'b0; hif.mem_brtaken = 1'b1;
        cycle("s5.h1"); cycle("s5.h2");
        do_reset();
        cycle("s5.rst");
        nRST = 1'b1;
        idle();

        // Saturation of the stall counter
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1 release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        hif.ihit = 1'b0;
        cycle("s6.a"); cycle("s6.b"); cycle("s6.c");
        chk("s6.sat", hif.stall_cnt, 32'hFFFF_FFFF);
        idle();
        do_reset(); cycle("s6.rst"); nRST = 1'b1;

        for (int i = 0; i < 800; i++) begin
            hif.ihit        = ($urandom_range(0, 3) != 0);
            hif.mem_dREN    = ($urandom_range(0, 5) == 0);
            hif.mem_dWEN    = ($urandom_range(0, 9) == 0);
            hif.dhit        = ($urandom_range(0, 1) == 0);
            hif.ex_dREN     = ($urandom_range(0, 2) == 0);
            hif.ex_rt       = 5'($urandom_range(0, 3));
            hif.id_rs       = 5'($urandom_range(0, 3));
            hif.id_rt       = 5'($urandom_range(0, 3));
            hif.id_usesrt   = $urandom_range(0, 1) == 1;
            hif.id_jump     = ($urandom_range(0, 5) == 0);
            hif.mem_brtaken = ($urandom_range(0, 6) == 0);
            hif.wb_halt     = ($urandom_range(0, 120) == 0);
            if ($urandom_range(0, 60) == 0) do_reset();
            else nRST = 1'b1;
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
